id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection and bubble/flush insertion.
- Captures decoded operands and control from ID each cycle.
- Its registered ID_EX_Rs/ID_EX_Rt/ID_EX_RegWrite/ID_EX_MemRead outputs feed the EX-stage forwarding unit, ALU and EX/MEM register.
- Drives PCWrite/IF_ID_Write to freeze PC and IF/ID on a load-use stall; counts inserted bubbles and flushes for performance debug.

---
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core: captures decoded operands and
// control, detects load-use hazards, inserts stall/flush bubbles and counts them.
module id_ex_stage #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IF_ID_Rs,
   input  logic [4:0]       IF_ID_Rt,
   input  logic [4:0]       IF_ID_Rd,
   input  logic             IF_ID_UsesRt,
   input  logic             IF_ID_Valid,
   input  logic [31:0]      ReadData1,
   input  logic [31:0]      ReadData2,
   input  logic [31:0]      SignExtImm,
   input  logic [31:0]      PCPlus4,
   input  logic             RegWrite,
   input  logic             MemtoReg,
   input  logic             MemRead,
   input  logic             MemWrite,
   input  logic             ALUSrc,
   input  logic             RegDst,
   input  logic [1:0]       ALUOp,
   input  logic             Flush,
   output logic [4:0]       ID_EX_Rs,
   output logic [4:0]       ID_EX_Rt,
   output logic [4:0]       ID_EX_Rd,
   output logic [31:0]      ID_EX_Data1,
   output logic [31:0]      ID_EX_Data2,
   output logic [31:0]      ID_EX_Imm,
   output logic [31:0]      ID_EX_PCPlus4,
   output logic             ID_EX_RegWrite,
   output logic             ID_EX_MemtoReg,
   output logic             ID_EX_MemRead,
   output logic             ID_EX_MemWrite,
   output logic             ID_EX_ALUSrc,
   output logic             ID_EX_RegDst,
   output logic [1:0]       ID_EX_ALUOp,
   output logic             ID_EX_Valid,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             Stall,
   output logic [CNT_W-1:0] BubbleCount,
   output logic [CNT_W-1:0] FlushCount
);

   logic [4:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [31:0]      data1_q, data1_d, data2_q, data2_d, imm_q, imm_d, pc_q, pc_d;
   logic             regwrite_q, regwrite_d, memtoreg_q, memtoreg_d;
   logic             memread_q, memread_d, memwrite_q, memwrite_d;
   logic             alusrc_q, alusrc_d, regdst_q, regdst_d;
   logic [1:0]       aluop_q, aluop_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d, fcnt_q, fcnt_d;
   logic             load_use, stall, bubble;

   assign load_use = valid_q & memread_q & (rt_q != 5'd0) & IF_ID_Valid &
                     ((rt_q == IF_ID_Rs) | (IF_ID_UsesRt & (rt_q == IF_ID_Rt)));
   // A taken branch discards the dependent instruction, so the flush wins over the stall.
   assign stall  = load_use & ~Flush;
   assign bubble = stall | Flush;

   always_comb begin
      rs_d       = IF_ID_Rs;
      rt_d       = IF_ID_Rt;
      rd_d       = IF_ID_Rd;
      data1_d    = ReadData1;
      data2_d    = ReadData2;
      imm_d      = SignExtImm;
      pc_d       = PCPlus4;
      regwrite_d = RegWrite & IF_ID_Valid;
      memtoreg_d = MemtoReg & IF_ID_Valid;
      memread_d  = MemRead & IF_ID_Valid;
      memwrite_d = MemWrite & IF_ID_Valid;
      alusrc_d   = ALUSrc & IF_ID_Valid;
      regdst_d   = RegDst & IF_ID_Valid;
      aluop_d    = IF_ID_Valid ? ALUOp : 2'b00;
      valid_d    = IF_ID_Valid;
      if (bubble) begin
         rs_d       = '0;
         rt_d       = '0;
         rd_d       = '0;
         data1_d    = '0;
         data2_d    = '0;
         imm_d      = '0;
         pc_d       = '0;
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         alusrc_d   = 1'b0;
         regdst_d   = 1'b0;
         aluop_d    = '0;
         valid_d    = 1'b0;
      end
      bcnt_d = bcnt_q;
      if (stall && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_W'(1);
      fcnt_d = fcnt_q;
      if (Flush && (fcnt_q != '1)) fcnt_d = fcnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         data1_q    <= '0;
         data2_q    <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         alusrc_q   <= 1'b0;
         regdst_q   <= 1'b0;
         aluop_q    <= '0;
         valid_q    <= 1'b0;
         bcnt_q     <= '0;
         fcnt_q     <= '0;
      end else begin
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         data1_q    <= data1_d;
         data2_q    <= data2_d;
         imm_q      <= imm_d;
         pc_q       <= pc_d;
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         alusrc_q   <= alusrc_d;
         regdst_q   <= regdst_d;
         aluop_q    <= aluop_d;
         valid_q    <= valid_d;
         bcnt_q     <= bcnt_d;
         fcnt_q     <= fcnt_d;
      end
   end

   assign ID_EX_Rs       = rs_q;
   assign ID_EX_Rt       = rt_q;
   assign ID_EX_Rd       = rd_q;
   assign ID_EX_Data1    = data1_q;
   assign ID_EX_Data2    = data2_q;
   assign ID_EX_Imm      = imm_q;
   assign ID_EX_PCPlus4  = pc_q;
   assign ID_EX_RegWrite = regwrite_q;
   assign ID_EX_MemtoReg = memtoreg_q;
   assign ID_EX_MemRead  = memread_q;
   assign ID_EX_MemWrite = memwrite_q;
   assign ID_EX_ALUSrc   = alusrc_q;
   assign ID_EX_RegDst   = regdst_q;
   assign ID_EX_ALUOp    = aluop_q;
   assign ID_EX_Valid    = valid_q;
   assign Stall          = stall;
   assign PCWrite        = ~stall;
   assign IF_ID_Write    = ~stall;
   assign BubbleCount    = bcnt_q;
   assign FlushCount     = fcnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a 16-bit counter instance and a 2-bit counter
// instance share stimulus; expected EX-stage contents flow through a scoreboard queue.
module tb_id_ex_stage;

   typedef struct packed {
      logic [4:0]  rs, rt, rd;
      logic [31:0] d1, d2, imm, pc;
      logic [7:0]  ctrl;     // {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,RegDst,ALUOp}
      logic        valid;
      logic [15:0] bc16, fc16;
      logic [1:0]  bc2, fc2;
   } exp_t;

   logic clk = 1'b0, reset = 1'b1;
   logic [4:0]  rs_i, rt_i, rd_i;
   logic        usesrt_i, valid_i, flush_i;
   logic [31:0] d1_i, d2_i, imm_i, pc_i;
   logic [7:0]  ctrl_i;

   logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
   logic [31:0] a_d1, a_d2, a_imm, a_pc, b_d1, b_d2, b_imm, b_pc;
   logic        a_rw, a_m2r, a_mr, a_mw, a_as, a_rdst, a_v, a_pcw, a_ifw, a_st;
   logic        b_rw, b_m2r, b_mr, b_mw, b_as, b_rdst, b_v, b_pcw, b_ifw, b_st;
   logic [1:0]  a_op, b_op;
   logic [15:0] a_bc, a_fc;
   logic [1:0]  b_bc, b_fc;

   int   tests = 0, fails = 0;
   exp_t sb_q[$];
   logic [15:0] bc16_m, fc16_m;
   logic [1:0]  bc2_m, fc2_m;

   always #5 clk = ~clk;

   id_ex_stage #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .IF_ID_Rs(rs_i), .IF_ID_Rt(rt_i), .IF_ID_Rd(rd_i),
      .IF_ID_UsesRt(usesrt_i), .IF_ID_Valid(valid_i), .ReadData1(d1_i), .ReadData2(d2_i),
      .SignExtImm(imm_i), .PCPlus4(pc_i), .RegWrite(ctrl_i[7]), .MemtoReg(ctrl_i[6]),
      .MemRead(ctrl_i[5]), .MemWrite(ctrl_i[4]), .ALUSrc(ctrl_i[3]), .RegDst(ctrl_i[2]),
      .ALUOp(ctrl_i[1:0]), .Flush(flush_i), .ID_EX_Rs(a_rs), .ID_EX_Rt(a_rt), .ID_EX_Rd(a_rd),
      .ID_EX_Data1(a_d1), .ID_EX_Data2(a_d2), .ID_EX_Imm(a_imm), .ID_EX_PCPlus4(a_pc),
      .ID_EX_RegWrite(a_rw), .ID_EX_MemtoReg(a_m2r), .ID_EX_MemRead(a_mr),
      .ID_EX_MemWrite(a_mw), .ID_EX_ALUSrc(a_as), .ID_EX_RegDst(a_rdst), .ID_EX_ALUOp(a_op),
      .ID_EX_Valid(a_v), .PCWrite(a_pcw), .IF_ID_Write(a_ifw), .Stall(a_st),
      .BubbleCount(a_bc), .FlushCount(a_fc));

   id_ex_stage #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .IF_ID_Rs(rs_i), .IF_ID_Rt(rt_i), .IF_ID_Rd(rd_i),
      .IF_ID_UsesRt(usesrt_i), .IF_ID_Valid(valid_i), .ReadData1(d1_i), .ReadData2(d2_i),
      .SignExtImm(imm_i), .PCPlus4(pc_i), .RegWrite(ctrl_i[7]), .MemtoReg(ctrl_i[6]),
      .MemRead(ctrl_i[5]), .MemWrite(ctrl_i[4]), .ALUSrc(ctrl_i[3]), .RegDst(ctrl_i[2]),
      .ALUOp(ctrl_i[1:0]), .Flush(flush_i), .ID_EX_Rs(b_rs), .ID_EX_Rt(b_rt), .ID_EX_Rd(b_rd),
      .ID_EX_Data1(b_d1), .ID_EX_Data2(b_d2), .ID_EX_Imm(b_imm), .ID_EX_PCPlus4(b_pc),
      .ID_EX_RegWrite(b_rw), .ID_EX_MemtoReg(b_m2r), .ID_EX_MemRead(b_mr),
      .ID_EX_MemWrite(b_mw), .ID_EX_ALUSrc(b_as), .ID_EX_RegDst(b_rdst), .ID_EX_ALUOp(b_op),
      .ID_EX_Valid(b_v), .PCWrite(b_pcw), .IF_ID_Write(b_ifw), .Stall(b_st),
      .BubbleCount(b_bc), .FlushCount(b_fc));

   function automatic exp_t observed();
      exp_t o;
      o.rs = a_rs; o.rt = a_rt; o.rd = a_rd;
      o.d1 = a_d1; o.d2 = a_d2; o.imm = a_imm; o.pc = a_pc;
      o.ctrl = {a_rw, a_m2r, a_mr, a_mw, a_as, a_rdst, a_op};
      o.valid = a_v;
      o.bc16 = a_bc; o.fc16 = a_fc; o.bc2 = b_bc; o.fc2 = b_fc;
      return o;
   endfunction

   task automatic check_state(input string tag, input exp_t obs, input exp_t exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // {Stall, PCWrite, IF_ID_Write} of both instances
   task automatic check_hz(input string tag, input logic s);
      logic [5:0] obs, exp;
      obs = {a_st, a_pcw, a_ifw, b_st, b_pcw, b_ifw};
      exp = {s, ~s, ~s, s, ~s, ~s};
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s hazard observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs, rt, rd, input logic usesrt, valid,
                        input logic [7:0] ctrl, input logic [31:0] d1, d2, imm, pc,
                        input logic flush);
      rs_i = rs; rt_i = rt; rd_i = rd; usesrt_i = usesrt; valid_i = valid;
      ctrl_i = ctrl; d1_i = d1; d2_i = d2; imm_i = imm; pc_i = pc; flush_i = flush;
   endtask

   // Checks the hazard outputs for the driven ID inputs, then one edge later the EX copy.
   task automatic step(input string tag, input logic exp_stall);
      exp_t e;
      #1;
      check_hz(tag, exp_stall);
      e = '0;
      if (!(flush_i || exp_stall)) begin
         e.rs = rs_i; e.rt = rt_i; e.rd = rd_i;
         e.d1 = d1_i; e.d2 = d2_i; e.imm = imm_i; e.pc = pc_i;
         e.ctrl = valid_i ? ctrl_i : 8'h00;
         e.valid = valid_i;
      end
      if (exp_stall) begin
         if (bc16_m != 16'hFFFF) bc16_m = bc16_m + 16'd1;
         if (bc2_m != 2'b11) bc2_m = bc2_m + 2'd1;
      end
      if (flush_i) begin
         if (fc16_m != 16'hFFFF) fc16_m = fc16_m + 16'd1;
         if (fc2_m != 2'b11) fc2_m = fc2_m + 2'd1;
      end
      e.bc16 = bc16_m; e.fc16 = fc16_m; e.bc2 = bc2_m; e.fc2 = fc2_m;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, observed());
      end else begin
         check_state(tag, observed(), sb_q.pop_front());
      end
   endtask

   localparam logic [7:0] C_RTYPE = 8'b1000_0110;
   localparam logic [7:0] C_LW    = 8'b1110_1000;
   localparam logic [7:0] C_ADDI  = 8'b1000_1000;

   initial begin
      bc16_m = '0; fc16_m = '0; bc2_m = '0; fc2_m = '0;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      #2;
      check_state("reset_state", observed(), '0);
      check_hz("reset_hz", 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_RTYPE, 32'h11, 32'h22, 32'h0, 32'h104, 1'b0);
      step("passthrough_add", 1'b0);
      drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, C_LW, 32'h1000, 32'h0, 32'h4, 32'h108, 1'b0);
      step("lw_after_add", 1'b0);
      drive(5'd2, 5'd3, 5'd4, 1'b1, 1'b1, C_RTYPE, 32'h0, 32'h33, 32'h0, 32'h10C, 1'b0);
      step("loaduse_stall", 1'b1);
      step("loaduse_release", 1'b0);

      drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, C_LW, 32'h1000, 32'h0, 32'h8, 32'h110, 1'b0);
      step("lw_again", 1'b0);
      drive(5'd6, 5'd2, 5'd0, 1'b0, 1'b1, C_ADDI, 32'h66, 32'h0, 32'h7, 32'h114, 1'b0);
      step("rt_unused_no_stall", 1'b0);
      drive(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, C_LW, 32'h1000, 32'h0, 32'hC, 32'h118, 1'b0);
      step("lw_to_r0", 1'b0);
      drive(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, C_RTYPE, 32'h0, 32'h0, 32'h0, 32'h11C, 1'b0);
      step("r0_consumer_no_stall", 1'b0);

      drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, C_LW, 32'h1000, 32'h0, 32'h10, 32'h120, 1'b0);
      step("lw_before_flush", 1'b0);
      drive(5'd2, 5'd3, 5'd4, 1'b1, 1'b1, C_RTYPE, 32'h0, 32'h33, 32'h0, 32'h124, 1'b1);
      step("flush_beats_stall", 1'b0);

      drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, C_LW, 32'h1000, 32'h0, 32'h14, 32'h128, 1'b0);
      step("lw_before_invalid", 1'b0);
      drive(5'd2, 5'd2, 5'd5, 1'b1, 1'b0, C_RTYPE, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      step("invalid_no_stall", 1'b0);

      drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, C_LW, 32'h1000, 32'h0, 32'h18, 32'h12C, 1'b0);
      step("lw_before_reset", 1'b0);
      drive(5'd2, 5'd3, 5'd4, 1'b1, 1'b1, C_RTYPE, 32'h0, 32'h33, 32'h0, 32'h130, 1'b0);
      #1;
      check_hz("pre_reset_stall", 1'b1);
      reset = 1'b1;
      #1;
      check_state("async_reset", observed(), '0);
      check_hz("async_reset_hz", 1'b0);
      bc16_m = '0; fc16_m = '0; bc2_m = '0; fc2_m = '0;
      #1;
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, C_LW, 32'h1000, 32'h0, 32'h20, 32'h200, 1'b0);
         step("sat_lw", 1'b0);
         drive(5'd2, 5'd3, 5'd4, 1'b1, 1'b1, C_RTYPE, 32'h0, 32'h33, 32'h0, 32'h204, 1'b0);
         step("sat_bubble", 1'b1);
      end
      step("sat_final_release", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
